// File: rtl/rx_buffer_fifo.sv
// First-word-fall-through receive buffer fed by the RX channel strobe, with rx_hold back-pressure.
// Define RXFIFO_OVF_EN to add the sticky ovf flag and the saturating drop_cnt counter.
module rx_buffer_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int SKID  = 1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic [WIDTH-1:0]         rx_data,
  input  logic                     rx_new_data,
  output logic                     rx_hold,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef RXFIFO_OVF_EN
  ,
  output logic                     ovf,
  output logic [7:0]               drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LVL = CW'(DEPTH);
  localparam logic [CW-1:0] HOLD_LVL = CW'(DEPTH - SKID);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;
  logic             drop;

  // Handshake: the consumer pops when rd_valid & rd_ready are both high on a rising
  // edge; rd_data is the head word and holds steady while rd_valid & !rd_ready.
  // The RX side has no ready: a strobe into a full FIFO without a pop is a drop.
  always_comb begin
    pop  = rd_valid & rd_ready;
    push = rx_new_data & ((count < FULL_LVL) | pop);
    drop = rx_new_data & ~push;
  end

  assign rd_valid = (count != '0);
  assign rd_data  = rd_valid ? mem[rptr] : '0;
  assign rx_hold  = (count >= HOLD_LVL);

  // Storage is deliberately not reset; rd_data masking hides stale contents.
  always_ff @(posedge ACLK) begin
    if (push) mem[wptr] <= rx_data;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef RXFIFO_OVF_EN
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_rx_buffer_fifo.sv
// Directed bench for rx_buffer_fifo at WIDTH=8, DEPTH=4, SKID=1.
// Overflow-flag checks are active when RXFIFO_OVF_EN is defined for the build.
module tb_rx_buffer_fifo;

  logic       ACLK;
  logic       ARESET;
  logic [7:0] rx_data;
  logic       rx_new_data;
  logic       rx_hold;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [2:0] count;
`ifdef RXFIFO_OVF_EN
  logic       ovf;
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  rx_buffer_fifo #(.WIDTH(8), .DEPTH(4), .SKID(1)) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .rx_data(rx_data),
    .rx_new_data(rx_new_data),
    .rx_hold(rx_hold),
    .rd_data(rd_data),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .count(count)
`ifdef RXFIFO_OVF_EN
    ,
    .ovf(ovf),
    .drop_cnt(drop_cnt)
`endif
  );

  // clock / reset
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic nd, input logic [7:0] d, input logic rr);
    rx_new_data = nd;
    rx_data     = d;
    rd_ready    = rr;
    @(posedge ACLK);
    #1;
    rx_new_data = 1'b0;
    rx_data     = 8'h00;
    rd_ready    = 1'b0;
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    ARESET = 1'b0;
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", rd_valid); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", rd_data); end
    n_checks++; if (rx_hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold: got %b want 0", rx_hold); end
`ifdef RXFIFO_OVF_EN
    n_checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rst_ovf: got %b/%0d want 0/0", ovf, drop_cnt); end
`endif
  endtask

  task automatic test_single();
    cyc(1'b1, 8'hA5, 1'b0);
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b want 1", rd_valid); end
    n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h want a5", rd_data); end
    n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count); end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 8'h00, 1'b0);
      n_checks++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_stable%0d: got %h want a5", i, rd_data); end
    end
    cyc(1'b0, 8'h00, 1'b1);
    n_checks++; if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL single_pop: got cnt=%0d v=%b d=%h want 0/0/00", count, rd_valid, rd_data);
    end
  endtask

  // Drains exp_q expecting rx_hold high at counts 3..4 and low below.
  task automatic drain(input string tag);
    int left;
    while (exp_q.size() > 0) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      n_checks++; if (rd_valid !== 1'b1 || rd_data !== e) begin
        n_fail++; $display("FAIL %s_head: got v=%b d=%h want 1/%h", tag, rd_valid, rd_data, e);
      end
      cyc(1'b0, 8'h00, 1'b1);
      left = exp_q.size();
      n_checks++; if (count !== 3'(left) || rx_hold !== (left >= 3)) begin
        n_fail++; $display("FAIL %s_cnt: got cnt=%0d hold=%b want %0d/%b", tag, count, rx_hold, left, left >= 3);
      end
    end
    n_checks++; if (rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      n_fail++; $display("FAIL %s_empty: got v=%b d=%h want 0/00", tag, rd_valid, rd_data);
    end
  endtask

  task automatic test_fill_overflow();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    n_checks++; if (count !== 3'd2 || rx_hold !== 1'b0) begin n_fail++; $display("FAIL fill_2: got cnt=%0d hold=%b want 2/0", count, rx_hold); end
    cyc(1'b1, 8'h33, 1'b0);
    n_checks++; if (count !== 3'd3 || rx_hold !== 1'b1) begin n_fail++; $display("FAIL fill_3: got cnt=%0d hold=%b want 3/1", count, rx_hold); end
    cyc(1'b1, 8'h44, 1'b0);
    n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL fill_4: got %0d want 4", count); end
    cyc(1'b1, 8'h55, 1'b0);
    n_checks++; if (count !== 3'd4 || rd_data !== 8'h11) begin n_fail++; $display("FAIL ovf_keep: got cnt=%0d d=%h want 4/11", count, rd_data); end
`ifdef RXFIFO_OVF_EN
    n_checks++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL ovf_flag: got %b/%0d want 1/1", ovf, drop_cnt); end
`endif
    exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    drain("fill");
  endtask

  task automatic test_full_push_pop();
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    cyc(1'b1, 8'h44, 1'b0);
    n_checks++; if (count !== 3'd4 || rd_data !== 8'h11) begin n_fail++; $display("FAIL fpp_pre: got cnt=%0d d=%h want 4/11", count, rd_data); end
    cyc(1'b1, 8'h66, 1'b1);
    n_checks++; if (count !== 3'd4 || rd_data !== 8'h22) begin n_fail++; $display("FAIL fpp_both: got cnt=%0d d=%h want 4/22", count, rd_data); end
`ifdef RXFIFO_OVF_EN
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL fpp_drop: got %0d want 1", drop_cnt); end
`endif
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
    drain("fpp");
  endtask

  task automatic test_empty_push_ready();
    cyc(1'b1, 8'h77, 1'b1);
    n_checks++; if (count !== 3'd1 || rd_valid !== 1'b1 || rd_data !== 8'h77) begin
      n_fail++; $display("FAIL epr: got cnt=%0d v=%b d=%h want 1/1/77", count, rd_valid, rd_data);
    end
    cyc(1'b0, 8'h00, 1'b1);
    n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL epr_pop: got %0d want 0", count); end
  endtask

  // Interleaved traffic; the bench tracks occupancy and order itself.
  task automatic test_wrap();
    int next_v = 1;
    int occ = 0;
    int seen = 0;
    int cyc_n = 0;
    logic do_push, do_pop, rr;
    exp_q.delete();
    while ((next_v <= 10 || occ > 0) && cyc_n < 200) begin
      do_push = (next_v <= 10) && (occ < 3) && ($urandom_range(0, 3) != 0);
      rr      = (next_v > 10) ? 1'b1 : 1'($urandom_range(0, 1));
      do_pop  = rr && (occ > 0);
      n_checks++; if (rd_valid !== (occ > 0)) begin n_fail++; $display("FAIL wrap_valid: got %b want %b", rd_valid, occ > 0); end
      if (do_pop) begin
        n_checks++; if (rd_data !== exp_q[0]) begin n_fail++; $display("FAIL wrap_data: got %h want %h", rd_data, exp_q[0]); end
        void'(exp_q.pop_front());
        seen++;
      end
      if (do_push) exp_q.push_back(8'(next_v));
      cyc(do_push, 8'(next_v), rr);
      if (do_push) next_v++;
      occ = occ + int'(do_push) - int'(do_pop);
      cyc_n++;
      n_checks++; if (count !== 3'(occ)) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count, occ); end
    end
    n_checks++; if (seen !== 10) begin n_fail++; $display("FAIL wrap_seen: got %0d want 10", seen); end
`ifdef RXFIFO_OVF_EN
    n_checks++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL wrap_drop: got %0d want 1", drop_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    cyc(1'b1, 8'hC1, 1'b0);
    cyc(1'b1, 8'hC2, 1'b0);
    cyc(1'b1, 8'hC3, 1'b0);
    n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL rmid_pre: got %0d want 3", count); end
    ARESET = 1'b1;
    cyc(1'b1, 8'hC4, 1'b1);
    ARESET = 1'b0;
    n_checks++; if (count !== 3'd0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || rx_hold !== 1'b0) begin
      n_fail++; $display("FAIL rmid: got cnt=%0d v=%b d=%h hold=%b want 0/0/00/0", count, rd_valid, rd_data, rx_hold);
    end
`ifdef RXFIFO_OVF_EN
    n_checks++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL rmid_ovf: got %b/%0d want 0/0", ovf, drop_cnt); end
`endif
    cyc(1'b1, 8'h3C, 1'b0);
    n_checks++; if (count !== 3'd1 || rd_data !== 8'h3C) begin n_fail++; $display("FAIL rmid_after: got cnt=%0d d=%h want 1/3c", count, rd_data); end
  endtask

  initial begin
    ARESET      = 1'b1;
    rx_new_data = 1'b0;
    rx_data     = 8'h00;
    rd_ready    = 1'b0;
    test_reset();
    test_single();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_ready();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_buffer_fifo.md
# rx_buffer_fifo

Receive-side word buffer sitting directly downstream of the RX channel. It captures each word the RX channel presents with `rx_new_data` and stores it in a first-word-fall-through FIFO for the consumer. It drives `rx_hold` back to the RX channel so the channel stops accepting beats before the buffer overruns. It replaces the ad-hoc single-word memory model currently used around the RX channel.

## Interface
- `WIDTH`, 8: data word width; must match the RX channel `WIDTH`.
- `DEPTH`, 8: number of storage entries; power of two, ≥2.
- `SKID`, 1: headroom entries reserved for words already in flight when `rx_hold` rises; range 0..DEPTH-1.

- `ACLK`  in  1  clock; all logic on the rising edge.
- `ARESET`  in  1  reset; synchronous, active-high.
- `rx_data`  in  WIDTH  word from the RX channel; valid only in cycles where `rx_new_data`=1.
- `rx_new_data`  in  1  one-cycle strobe; RX channel has a new word on `rx_data`.
- `rx_hold`  out  1  back-pressure to the RX channel; 1 = do not accept further beats.
- `rd_data`  out  WIDTH  head-of-FIFO word; forced to 0 when `rd_valid`=0.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_ready`  in  1  consumer pops the head when `rd_valid & rd_ready`.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `ovf`  out  1  sticky overflow flag (only with `RXFIFO_OVF_EN`).
- `drop_cnt`  out  8  count of dropped words, saturating at 255 (only with `RXFIFO_OVF_EN`).

## Operation
- Storage: DEPTH×WIDTH register array; write pointer and read pointer of width $clog2(DEPTH), wrapping naturally modulo DEPTH; occupancy register `count`.
- push = `rx_new_data & (count<DEPTH | pop)`; pop = `rd_valid & rd_ready`.
- On push: mem[wptr]←rx_data, wptr+1. On pop: rptr+1.
- count: +1 on push only, −1 on pop only, unchanged on both or neither.
- `rx_new_data` with count==DEPTH and no pop: word dropped; no pointer or count change.
- `rd_valid` = (count≠0); `rd_data` = rd_valid ? mem[rptr] : 0 (fall-through, no read latency).
- `rx_hold` = (count ≥ DEPTH−SKID), decoded from the registered `count`.
- Reset: wptr=rptr=0, count=0, hence rd_valid=0, rd_data=0, rx_hold=0; ovf=0, drop_cnt=0. Memory contents are not cleared. Reset overrides any simultaneous push or pop, including mid-burst.

## Timing
- Write-to-read latency: a word pushed in cycle N is visible on `rd_data` with `rd_valid`=1 in cycle N+1.
- Empty with simultaneous `rx_new_data` and `rd_ready`: no pop (rd_valid=0); count=1 in the next cycle.
- Full with simultaneous `rx_new_data` and pop: both happen; count stays DEPTH; no drop.
- `rx_hold` updates in the cycle after the push or pop that changes `count` across the threshold.
- The RX channel may deliver up to SKID further words after `rx_hold` rises; all of them fit without loss.
- `rd_data` changes only on the edge after a pop or push-into-empty; it is stable while `rd_valid & !rd_ready`.

## Configuration
- `RXFIFO_OVF_EN` defined:
  - `ovf` and `drop_cnt` ports exist.
  - Each dropped word sets `ovf`, which stays set until reset.
  - Each dropped word increments `drop_cnt` by 1, saturating at 255.
- `RXFIFO_OVF_EN` undefined:
  - Both ports and their registers are absent.
  - Dropped words are silently discarded.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8, DEPTH=4, SKID=1, with `RXFIFO_OVF_EN` defined.
- Reset mid-operation: count=3, ARESET=1 for 1 cycle -> next cycle count=0, rd_valid=0, rd_data=0x00, rx_hold=0, ovf=0, drop_cnt=0.
- Single word: strobe 0xA5, rd_ready=0 -> next cycle rd_valid=1, rd_data=0xA5, count=1; hold rd_ready=0 for 3 cycles -> rd_data stays 0xA5.
- Fill and overflow, rd_ready=0:
  - Strobe 0x11, 0x22, 0x33 -> count=3, rx_hold=1.
  - Strobe 0x44 -> accepted, count=4.
  - Strobe 0x55 -> dropped, ovf=1, drop_cnt=1.
  - Drain -> reads 0x11, 0x22, 0x33, 0x44 in order; rx_hold falls after the count drops to 2.
- Full with simultaneous push and pop: count=4, head 0x11, strobe 0x66 with rd_ready=1 -> 0x11 consumed, count=4, drop_cnt unchanged; 0x66 is the last word drained.
- Empty with simultaneous push and ready: strobe 0x77 with rd_ready=1 and count=0 -> no pop; next cycle count=1, rd_data=0x77.
- Wrap-around: interleave pushes 0x01..0x0A with random rd_ready (occupancy never exceeds 3) -> consumer sees 0x01..0x0A in order with no drop, and pointers wrap at least twice.
